// File: rtl/eeg_epoch_streamer.sv
// Drives one EEG epoch into the accelerator: frames the load, streams a fixed
// number of buffered ADC samples with a minimum strobe spacing, then waits for completion.
module eeg_epoch_streamer #(
  parameter  int ADC_W             = 16,
  parameter  int SAMPLES_PER_EPOCH = 3000,
  parameter  int FIFO_DEPTH        = 8,
  parameter  int MIN_GAP           = 2,
  parameter  int TIMEOUT_CYCLES    = 1 << 20,
  localparam int CNT_W             = $clog2(SAMPLES_PER_EPOCH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             epoch_start,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  output logic             adc_ready,
  output logic             new_sleep_epoch,
  output logic             start_eeg_load,
  output logic             new_eeg_data,
  output logic [ADC_W-1:0] eeg,
  input  logic             inference_complete,
  output logic             busy,
  output logic             done_pulse,
  output logic             timeout_err,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int GAP_W  = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef logic [ADC_W-1:0] adc_data_t;
  typedef enum logic [1:0] {IDLE, START, STREAM, WAIT_INF} state_t;

  state_t            state_q, state_d;
  adc_data_t         mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [FILL_W-1:0] fill, fill_next;
  logic [CNT_W-1:0]  acc_cnt, acc_next;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              push, pop, start_accept, tmo_hit, epoch_full, ready_d;

  assign fill         = wr_ptr - rd_ptr;
  assign push         = adc_valid & adc_ready;
  assign pop          = (state_q == STREAM) && (fill != '0) && (gap_cnt == '0);
  assign fill_next    = fill + FILL_W'(push) - FILL_W'(pop);
  assign acc_next     = acc_cnt + CNT_W'(push);
  assign start_accept = (state_q == IDLE) && epoch_start;
  assign tmo_hit      = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign epoch_full   = (sample_cnt == CNT_W'(SAMPLES_PER_EPOCH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE:     if (epoch_start) state_d = START;
      START:    state_d = STREAM;
      STREAM:   if (epoch_full) state_d = WAIT_INF;
      WAIT_INF: if (inference_complete || tmo_hit) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // adc_ready is registered, so it is computed from next-cycle occupancy and acceptance count.
    if (state_d == STREAM)
      ready_d = (fill_next < FILL_W'(FIFO_DEPTH)) && (acc_next < CNT_W'(SAMPLES_PER_EPOCH));
  end

  // NOTE: the sample buffer has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= adc_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      acc_cnt         <= '0;
      gap_cnt         <= '0;
      tmo_cnt         <= '0;
      sample_cnt      <= '0;
      eeg             <= '0;
      adc_ready       <= 1'b0;
      new_sleep_epoch <= 1'b0;
      start_eeg_load  <= 1'b0;
      new_eeg_data    <= 1'b0;
      busy            <= 1'b0;
      done_pulse      <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      new_sleep_epoch <= start_accept;
      start_eeg_load  <= start_accept;
      new_eeg_data    <= pop;
      done_pulse      <= (state_q == WAIT_INF) && inference_complete;
      busy            <= (state_d != IDLE);
      adc_ready       <= ready_d;
      tmo_cnt         <= ((state_q == WAIT_INF) && !tmo_hit) ? tmo_cnt + TMO_W'(1) : '0;

      if (start_accept) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        acc_cnt     <= '0;
        gap_cnt     <= '0;
        sample_cnt  <= '0;
        timeout_err <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + (PTR_W+1)'(1);
          if (acc_cnt != CNT_W'(SAMPLES_PER_EPOCH)) acc_cnt <= acc_next;
        end
        if (pop) begin
          rd_ptr  <= rd_ptr + (PTR_W+1)'(1);
          eeg     <= mem[rd_ptr[PTR_W-1:0]];
          gap_cnt <= GAP_W'(MIN_GAP);
          if (!epoch_full) sample_cnt <= sample_cnt + CNT_W'(1);
        end else if (gap_cnt != '0) begin
          gap_cnt <= gap_cnt - GAP_W'(1);
        end
        // Completion takes priority over a timeout landing in the same cycle.
        if ((state_q == WAIT_INF) && tmo_hit && !inference_complete) timeout_err <= 1'b1;
      end
    end
  end

endmodule
